mfe_led7seg_74hc595_scanner: RTL
================================

Name: mfe_led7seg_74hc595_scanner

Overview:
- Upstream feeder for the 8-digit 74HC595 7-seg controller.
- Holds a 32-bit hex value, per-digit decimal points and per-digit blanking.
- Encodes one digit at a time into a {segment, digit-select} word and time-multiplexes all digits over the controller's vld/rdy handshake.
- Double-buffered load: new values appear only at a frame boundary, so a frame never mixes old and new digits.

Parameters:
- SCAN_DIV, 0, extra dwell cycles after each accepted word before preparing the next digit (0 = back-to-back as fast as the controller accepts).
- DWELL_W, 16, width of the dwell counter; SCAN_DIV must be < 2**DWELL_W.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- in_val  input  32  hex value; nibble k drives digit k (digit 0 = bits 3:0).
- in_dp  input  8  bit k=1 lights the decimal point of digit k.
- in_blank  input  8  bit k=1 forces digit k fully dark.
- in_lzb  input  1  leading-zero blanking enable.
- in_load  input  1  single-cycle strobe; captures in_val/in_dp/in_blank/in_lzb into the shadow register.
- out_dat  output  16  {seg[7:0] active-low (bit7=DP, bits6:0=g..a), dig[7:0] one-hot}.
- out_vld  output  1  out_dat valid to the controller.
- out_rdy  input  1  controller ready; a transfer occurs when out_vld && out_rdy.
- frame_done  output  1  one-cycle pulse on the handshake of digit 7.
- pending  output  1  shadow holds data not yet committed.

Behaviour:
- Reset values: out_dat=16'hFF00, out_vld=0, frame_done=0, pending=0, digit index=0, active and shadow registers all zero (in_lzb=0, no blank, no DP), FSM=PREP.
- Hex encoding (seg[6:0] with bit7=1): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- DP: when dp[k]=1, seg bit7 is cleared (seg & 8'h7F).
- Blanked digit: seg=8'hFF, including DP. in_blank overrides DP.
- Leading-zero blanking (active lzb=1): scanning from digit 7 downward, each zero nibble is blanked until the first non-zero nibble. Digit 0 is never LZB-blanked. A DP on an LZB-blanked digit still lights (seg=8'h7F).
- dig field: 8'h01 << idx.
- FSM:
  - PREP (1 cycle): register out_dat for idx; set out_vld=1; go to SEND.
  - SEND: hold out_dat and out_vld stable until out_rdy. On the handshake: out_vld=0 next cycle, idx=idx+1 (mod 8). If SCAN_DIV=0 go to PREP, else load the dwell counter with SCAN_DIV-1 and go to DWELL.
  - DWELL: decrement the counter; at 0 go to PREP.
- Throughput with SCAN_DIV=0 and out_rdy=1: one word every 2 cycles. A word is presented the cycle after PREP.
- out_vld is never deasserted without a handshake, and out_dat never changes while out_vld=1.
- Load: in_load copies inputs to the shadow and sets pending=1. A later load before commit overwrites the shadow; the latest load wins.
- Commit: on the digit-7 handshake, if pending then active<=shadow and pending<=0. frame_done pulses in the same cycle regardless of pending.
- Load and commit in the same cycle: the old shadow commits, the new inputs go to the shadow, and pending stays 1.
- Encoding uses only the active register, sampled in PREP.
- rst mid-operation (any state, including SEND with out_vld=1): all registers return to reset values next cycle and the in-flight word is dropped.

Test Plan:
- Reset, then check for 3 cycles: out_dat=16'hFF00, out_vld=0, pending=0. First word after rst release is {C0,01} (digit 0 shows "0"); digits 1..7 also show C0.
- Load 32'h76543210, out_rdy=1, SCAN_DIV=0. Next frame after commit yields {C0,01},{F9,02},{A4,04},{B0,08},{99,10},{92,20},{82,40},{F8,80}, one every 2 cycles; frame_done pulses on the {F8,80} handshake.
- Load 32'h00000120 with lzb=1, dp=8'h01 -> digits 7..3 seg FF, digit 2 F9, digit 1 A4, digit 0 40 (zero with DP). Load 0 with lzb=1 -> only digit 0 shows C0.
- Hold out_rdy=0 for 20 cycles during SEND -> out_vld=1 and out_dat constant throughout; one cycle of out_rdy=1 advances exactly one digit.
- Load 32'hFFFFFFFF while digit 3 is in flight -> digits 4..7 of that frame keep old values, pending=1 until the digit-7 handshake, next frame shows 8E on all digits. in_load coincident with the digit-7 handshake -> pending stays 1.
- SCAN_DIV=4: gap from handshake to next out_vld is 4 dwell cycles + 1 PREP. Assert rst during SEND -> out_vld=0 and idx=0 next cycle.

Source files
------------

// File: rtl/mfe_led7seg_74hc595_scanner_if.sv
// Word stream from the scanner to the 74HC595 7-seg controller.
// out_dat {seg,dig}, out_vld source-driven, out_rdy sink-driven.
interface mfe_led7seg_74hc595_scanner_if;
  logic [15:0] out_dat;
  logic        out_vld;
  logic        out_rdy;

  modport master (
    output out_dat,
    output out_vld,
    input  out_rdy
  );

  modport slave (
    input  out_dat,
    input  out_vld,
    output out_rdy
  );
endinterface

// File: rtl/mfe_led7seg_74hc595_scanner.sv
// Scans 8 hex digits into {seg,dig} words over a vld/rdy stream.
// Ports: clk/rst, in_* load side, bus (master), frame_done, pending.
module mfe_led7seg_74hc595_scanner #(
  parameter int SCAN_DIV = 0,
  parameter int DWELL_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_val,
  input  logic [7:0]  in_dp,
  input  logic [7:0]  in_blank,
  input  logic        in_lzb,
  input  logic        in_load,
  mfe_led7seg_74hc595_scanner_if.master bus,
  output logic        frame_done,
  output logic        pending
);

  typedef enum logic [1:0] {
    PREP,
    SEND,
    DWELL
  } state_t;

  state_t             state_q;
  logic [2:0]         idx_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [15:0]        dat_q;
  logic               vld_q;
  logic               pend_q;

  logic [31:0] act_val_q, sh_val_q;
  logic [7:0]  act_dp_q, sh_dp_q;
  logic [7:0]  act_blank_q, sh_blank_q;
  logic        act_lzb_q, sh_lzb_q;

  logic [7:0]  lz_mask;
  logic [3:0]  nib;
  logic [7:0]  hex_seg;
  logic [7:0]  dp_mask;
  logic [7:0]  seg_d;
  logic [15:0] dat_d;
  logic        hs;
  logic        commit;
  logic        zrun;

  assign hs     = vld_q & bus.out_rdy;
  assign commit = hs & (idx_q == 3'd7);

  assign bus.out_dat = dat_q;
  assign bus.out_vld = vld_q;
  assign frame_done  = commit;
  assign pending     = pend_q;

  // Digit k is a leading zero if it and every digit above are zero.
  always_comb begin
    lz_mask = 8'h00;
    zrun    = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      zrun       = zrun & (act_val_q[k*4 +: 4] == 4'h0);
      lz_mask[k] = act_lzb_q & zrun;
    end
  end

  assign nib     = act_val_q[{idx_q, 2'b00} +: 4];
  assign dp_mask = act_dp_q[idx_q] ? 8'h7F : 8'hFF;

  always_comb begin
    hex_seg = 8'hFF;
    unique case (nib)
      4'h0: hex_seg = 8'hC0;
      4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;
      4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;
      4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;
      4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;
      4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;
      4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;
      4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;
      4'hF: hex_seg = 8'h8E;
    endcase
  end

  // Blank beats DP; a leading-zero digit still shows its DP.
  always_comb begin
    if (act_blank_q[idx_q]) begin
      seg_d = 8'hFF;
    end else if (lz_mask[idx_q]) begin
      seg_d = dp_mask;
    end else begin
      seg_d = hex_seg & dp_mask;
    end
    dat_d = {seg_d, 8'h01 << idx_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PREP;
      idx_q       <= 3'd0;
      dwell_q     <= '0;
      dat_q       <= 16'hFF00;
      vld_q       <= 1'b0;
      pend_q      <= 1'b0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      act_lzb_q   <= 1'b0;
      sh_val_q    <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      sh_lzb_q    <= 1'b0;
    end else begin
      // Old shadow commits even when a new load lands this cycle.
      if (commit && pend_q) begin
        act_val_q   <= sh_val_q;
        act_dp_q    <= sh_dp_q;
        act_blank_q <= sh_blank_q;
        act_lzb_q   <= sh_lzb_q;
      end
      if (in_load) begin
        sh_val_q   <= in_val;
        sh_dp_q    <= in_dp;
        sh_blank_q <= in_blank;
        sh_lzb_q   <= in_lzb;
        pend_q     <= 1'b1;
      end else if (commit) begin
        pend_q <= 1'b0;
      end

      unique case (state_q)
        PREP: begin
          dat_q   <= dat_d;
          vld_q   <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          if (bus.out_rdy) begin
            vld_q <= 1'b0;
            idx_q <= idx_q + 3'd1;
            if (SCAN_DIV == 0) begin
              state_q <= PREP;
            end else begin
              dwell_q <= DWELL_W'(SCAN_DIV - 1);
              state_q <= DWELL;
            end
          end
        end
        DWELL: begin
          if (dwell_q == '0) begin
            state_q <= PREP;
          end else begin
            dwell_q <= dwell_q - 1'b1;
          end
        end
        default: state_q <= PREP;
      endcase
    end
  end

endmodule
